// File: rtl/ili_rect_fill_pkg.sv
// Shared ILI9341 definitions: command opcodes, panel limits, rectangle-fill FSM
// states and the latched fill request.
package pkg_ili9341;

  localparam logic [7:0] ILI_CMD_CASET = 8'h2A;
  localparam logic [7:0] ILI_CMD_PASET = 8'h2B;
  localparam logic [7:0] ILI_CMD_RAMWR = 8'h2C;

  localparam int ILI_MAX_X = 239;
  localparam int ILI_MAX_Y = 319;

  // 240 x 320 = 76800 pixels needs 17 bits.
  localparam int PIX_CNT_W = 17;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_CASET_CMD,
    ST_CASET_DAT,
    ST_PASET_CMD,
    ST_PASET_DAT,
    ST_RAMWR_CMD,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_FINISH
  } e_rect_state;

  // Coordinates are held already zero-extended to the 16-bit wire format.
  typedef struct packed {
    logic [15:0] x0;
    logic [15:0] x1;
    logic [15:0] y0;
    logic [15:0] y1;
    logic [15:0] color;
  } st_rect_req;

  // Picks one of the four big-endian address-window parameter bytes.
  function automatic logic [7:0] coord_param_byte(input logic [15:0] first,
                                                  input logic [15:0] last,
                                                  input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = first[15:8];
      2'd1:    b = first[7:0];
      2'd2:    b = last[15:8];
      default: b = last[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ili_rect_fill_pixel_count.sv
// Pixel counter for a rectangle fill: loads width*height once, then counts
// down one per pixel so the FSM knows when the last pixel goes out.
module rect_pixel_count
  import pkg_ili9341::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_x0,
  input  logic [15:0] i_x1,
  input  logic [15:0] i_y0,
  input  logic [15:0] i_y1,
  input  logic        i_load,
  input  logic        i_dec,
  output logic        o_last
);

  logic [PIX_CNT_W-1:0] width;
  logic [PIX_CNT_W-1:0] height;
  logic [PIX_CNT_W-1:0] count;

  // Only meaningful once the request has passed the range check.
  assign width  = PIX_CNT_W'(i_x1) - PIX_CNT_W'(i_x0) + PIX_CNT_W'(1);
  assign height = PIX_CNT_W'(i_y1) - PIX_CNT_W'(i_y0) + PIX_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (i_load) begin
      count <= width * height;
    end else if (i_dec && (count != '0)) begin
      count <= count - PIX_CNT_W'(1);
    end
  end

  assign o_last = (count == PIX_CNT_W'(1));

endmodule

// File: rtl/ili_rect_fill.sv
// Turns a rectangle and RGB565 colour into the ILI9341 CASET/PASET/RAMWR byte
// stream, one byte per valid/ready transfer, each tagged with its D/C flag.
module ili_rect_fill
  import pkg_ili9341::*;
#(
  parameter int COORD_W = 9,
  parameter int MAX_X   = ILI_MAX_X,
  parameter int MAX_Y   = ILI_MAX_Y
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_x1,
  input  logic [COORD_W-1:0] i_y0,
  input  logic [COORD_W-1:0] i_y1,
  input  logic [15:0]        i_color,
  input  logic               i_byte_ready,
  output logic               o_byte_valid,
  output logic [7:0]         o_byte,
  output logic               o_dc,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam logic [15:0] MAX_X16 = 16'(MAX_X);
  localparam logic [15:0] MAX_Y16 = 16'(MAX_Y);

  e_rect_state state, state_n;
  st_rect_req  req, req_n;
  logic [1:0]  idx, idx_n;
  logic        valid_n, dc_n, busy_n, done_n, err_n;
  logic [7:0]  byte_n;
  logic        cnt_load, cnt_dec, cnt_last;
  logic        xfer;
  logic        req_bad;

  assign xfer    = o_byte_valid && i_byte_ready;
  assign req_bad = (req.x0 > req.x1) || (req.y0 > req.y1) ||
                   (req.x1 > MAX_X16) || (req.y1 > MAX_Y16);

  rect_pixel_count u_pixel_count (
    .clk    (clk),
    .rst    (rst),
    .i_x0   (req.x0),
    .i_x1   (req.x1),
    .i_y0   (req.y0),
    .i_y1   (req.y1),
    .i_load (cnt_load),
    .i_dec  (cnt_dec),
    .o_last (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      req          <= '0;
      idx          <= '0;
      o_byte_valid <= 1'b0;
      o_byte       <= 8'h00;
      o_dc         <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state        <= state_n;
      req          <= req_n;
      idx          <= idx_n;
      o_byte_valid <= valid_n;
      o_byte       <= byte_n;
      o_dc         <= dc_n;
      o_busy       <= busy_n;
      o_done       <= done_n;
      o_err        <= err_n;
    end
  end

  // Each sending state names the byte currently on o_byte; on a transfer the
  // next byte is loaded so the stream runs without bubbles.
  always_comb begin
    state_n  = state;
    req_n    = req;
    idx_n    = idx;
    valid_n  = o_byte_valid;
    byte_n   = o_byte;
    dc_n     = o_dc;
    busy_n   = o_busy;
    done_n   = 1'b0;
    err_n    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state)
      ST_IDLE: begin
        busy_n = 1'b0;
        // busy is still high for one IDLE cycle after a reject, so a start
        // there is ignored like any other start while busy.
        if (i_start && !o_busy) begin
          req_n.x0    = 16'(i_x0);
          req_n.x1    = 16'(i_x1);
          req_n.y0    = 16'(i_y0);
          req_n.y1    = 16'(i_y1);
          req_n.color = i_color;
          busy_n      = 1'b1;
          state_n     = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (req_bad) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          cnt_load = 1'b1;
          valid_n  = 1'b1;
          byte_n   = ILI_CMD_CASET;
          dc_n     = 1'b0;
          state_n  = ST_CASET_CMD;
        end
      end

      ST_CASET_CMD: begin
        if (xfer) begin
          idx_n   = 2'd0;
          byte_n  = coord_param_byte(req.x0, req.x1, 2'd0);
          dc_n    = 1'b1;
          state_n = ST_CASET_DAT;
        end
      end

      ST_CASET_DAT: begin
        if (xfer) begin
          if (idx == 2'd3) begin
            byte_n  = ILI_CMD_PASET;
            dc_n    = 1'b0;
            state_n = ST_PASET_CMD;
          end else begin
            idx_n  = idx + 2'd1;
            byte_n = coord_param_byte(req.x0, req.x1, idx + 2'd1);
          end
        end
      end

      ST_PASET_CMD: begin
        if (xfer) begin
          idx_n   = 2'd0;
          byte_n  = coord_param_byte(req.y0, req.y1, 2'd0);
          dc_n    = 1'b1;
          state_n = ST_PASET_DAT;
        end
      end

      ST_PASET_DAT: begin
        if (xfer) begin
          if (idx == 2'd3) begin
            byte_n  = ILI_CMD_RAMWR;
            dc_n    = 1'b0;
            state_n = ST_RAMWR_CMD;
          end else begin
            idx_n  = idx + 2'd1;
            byte_n = coord_param_byte(req.y0, req.y1, idx + 2'd1);
          end
        end
      end

      ST_RAMWR_CMD: begin
        if (xfer) begin
          byte_n  = req.color[15:8];
          dc_n    = 1'b1;
          state_n = ST_PIX_HI;
        end
      end

      ST_PIX_HI: begin
        if (xfer) begin
          byte_n  = req.color[7:0];
          state_n = ST_PIX_LO;
        end
      end

      ST_PIX_LO: begin
        if (xfer) begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            valid_n = 1'b0;
            byte_n  = 8'h00;
            dc_n    = 1'b0;
            done_n  = 1'b1;
            state_n = ST_FINISH;
          end else begin
            byte_n  = req.color[15:8];
            state_n = ST_PIX_HI;
          end
        end
      end

      ST_FINISH: begin
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end

      default: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ili_rect_fill.sv
// Self-checking bench for ili_rect_fill: a queue-based model of the expected
// byte stream is compared against every transfer, plus literal and timing pins.
module tb_ili_rect_fill;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [8:0]  i_x0 = '0, i_x1 = '0, i_y0 = '0, i_y1 = '0;
  logic [15:0] i_color = '0;
  logic        i_byte_ready = 1'b1;
  logic        o_byte_valid, o_dc, o_busy, o_done, o_err;
  logic [7:0]  o_byte;

  int checks = 0;
  int failures = 0;
  int readyMode = 0;
  int xferCount = 0;
  int doneCount = 0;
  int errCount = 0;
  logic [8:0] expQ[$];
  logic [8:0] capQ[$];
  bit         stallPending = 0;
  logic [8:0] held = '0;

  ili_rect_fill dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_x0         (i_x0),
    .i_x1         (i_x1),
    .i_y0         (i_y0),
    .i_y1         (i_y1),
    .i_color      (i_color),
    .i_byte_ready (i_byte_ready),
    .o_byte_valid (o_byte_valid),
    .o_byte       (o_byte),
    .o_dc         (o_dc),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    i_byte_ready = (readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  function automatic bit modelRejects(input int x0, input int y0, input int x1, input int y1);
    return (x0 > x1) || (y0 > y1) || (x1 > 239) || (y1 > 319);
  endfunction

  // Expected stream as {dc, byte}: command, then big-endian 16-bit coordinates.
  task automatic modelPush(input int x0, input int y0, input int x1, input int y1, input int color);
    int n;
    expQ.push_back({1'b0, 8'h2A});
    expQ.push_back({1'b1, 8'(x0 / 256)});
    expQ.push_back({1'b1, 8'(x0 % 256)});
    expQ.push_back({1'b1, 8'(x1 / 256)});
    expQ.push_back({1'b1, 8'(x1 % 256)});
    expQ.push_back({1'b0, 8'h2B});
    expQ.push_back({1'b1, 8'(y0 / 256)});
    expQ.push_back({1'b1, 8'(y0 % 256)});
    expQ.push_back({1'b1, 8'(y1 / 256)});
    expQ.push_back({1'b1, 8'(y1 % 256)});
    expQ.push_back({1'b0, 8'h2C});
    n = (x1 - x0 + 1) * (y1 - y0 + 1);
    for (int p = 0; p < n; p++) begin
      expQ.push_back({1'b1, 8'(color / 256)});
      expQ.push_back({1'b1, 8'(color % 256)});
    end
  endtask

  // Compare process: every transfer against the model, every stall for stability.
  always @(negedge clk) begin
    if (!rst) begin
      expQ.delete();
      stallPending = 0;
    end else begin
      if (stallPending) begin
        checkOutput("stall_valid", int'(o_byte_valid), 1);
        checkOutput("stall_hold", int'({o_dc, o_byte}), int'(held));
      end
      if (o_byte_valid && i_byte_ready) begin
        capQ.push_back({o_dc, o_byte});
        xferCount++;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL extra_byte actual=0x%0h expected=none", {o_dc, o_byte});
        end else begin
          checkOutput("stream", int'({o_dc, o_byte}), int'(expQ.pop_front()));
        end
        stallPending = 0;
      end else if (o_byte_valid) begin
        stallPending = 1;
        held = {o_dc, o_byte};
      end else begin
        stallPending = 0;
      end
      if (o_done) doneCount++;
      if (o_err) errCount++;
    end
  end

  task automatic pulseStart(input int x0, input int y0, input int x1, input int y1, input int color);
    i_x0 = 9'(x0); i_y0 = 9'(y0); i_x1 = 9'(x1); i_y1 = 9'(y1);
    i_color = 16'(color);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Called at posedge+1; returns at T+2 (accepted) or T+3 (rejected).
  task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1,
                               input int color, output bit rej);
    rej = modelRejects(x0, y0, x1, y1);
    capQ.delete();
    xferCount = 0;
    doneCount = 0;
    errCount  = 0;
    if (!rej) modelPush(x0, y0, x1, y1, color);
    pulseStart(x0, y0, x1, y1, color);
    checkOutput("busy_t1", int'(o_busy), 1);
    @(posedge clk); #1;
    if (rej) begin
      checkOutput("err_t2", int'(o_err), 1);
      checkOutput("err_busy_t2", int'(o_busy), 1);
      checkOutput("err_valid_t2", int'(o_byte_valid), 0);
      @(posedge clk); #1;
      checkOutput("err_busy_t3", int'(o_busy), 0);
      checkOutput("err_pulse_t3", int'(o_err), 0);
      checkOutput("err_count", errCount, 1);
      checkOutput("err_xfers", xferCount, 0);
    end else begin
      checkOutput("valid_t2", int'(o_byte_valid), 1);
      checkOutput("first_byte_t2", int'({o_dc, o_byte}), 'h02A);
    end
  endtask

  task automatic waitDone(input int nPix, input int limit);
    bit seen = 0;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #1;
      if (o_done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout actual=none expected=o_done within %0d cycles", limit);
    end else begin
      checkOutput("done_valid", int'(o_byte_valid), 0);
      checkOutput("done_busy", int'(o_busy), 1);
      checkOutput("done_leftover", expQ.size(), 0);
      checkOutput("done_xfers", xferCount, 11 + 2 * nPix);
      @(posedge clk); #1;
      checkOutput("idle_busy", int'(o_busy), 0);
      checkOutput("idle_done", int'(o_done), 0);
      checkOutput("done_count", doneCount, 1);
    end
  endtask

  task automatic waitXfers(input int target, input int limit);
    for (int c = 0; c < limit && xferCount < target; c++) begin
      @(posedge clk); #1;
    end
    if (xferCount < target) begin
      checks++;
      failures++;
      $display("[TB] FAIL xfer_timeout actual=%0d expected=%0d", xferCount, target);
    end
  endtask

  int litA[13] = '{'h02A, 'h100, 'h100, 'h100, 'h100, 'h02B, 'h100, 'h100, 'h100, 'h100,
                   'h02C, 'h1F8, 'h100};

  task automatic checkLiteralA(input string tag);
    checkOutput({tag, "_len"}, capQ.size(), 13);
    for (int i = 0; i < 13; i++)
      checkOutput($sformatf("%s_b%0d", tag, i), (capQ.size() > i) ? int'(capQ[i]) : -1, litA[i]);
  endtask

  initial begin
    bit rej;
    int x0, y0, x1, y1, n;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", int'(o_byte_valid), 0);
    checkOutput("rst_byte", int'(o_byte), 0);
    checkOutput("rst_dc", int'(o_dc), 0);
    checkOutput("rst_busy", int'(o_busy), 0);
    checkOutput("rst_done", int'(o_done), 0);
    checkOutput("rst_err", int'(o_err), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single pixel");
    readyMode = 0;
    applyStimulus(0, 0, 0, 0, 'hF800, rej);
    waitDone(1, 100);
    checkLiteralA("single");

    $display("[TB] narrow tall rect");
    applyStimulus(10, 5, 11, 300, 'h07E0, rej);
    waitDone(592, 3000);
    checkOutput("b_len", capQ.size(), 1195);
    if (capQ.size() == 1195) begin
      checkOutput("b_x0h", int'(capQ[1]), 'h100);
      checkOutput("b_x0l", int'(capQ[2]), 'h10A);
      checkOutput("b_x1h", int'(capQ[3]), 'h100);
      checkOutput("b_x1l", int'(capQ[4]), 'h10B);
      checkOutput("b_y0h", int'(capQ[6]), 'h100);
      checkOutput("b_y0l", int'(capQ[7]), 'h105);
      checkOutput("b_y1h", int'(capQ[8]), 'h101);
      checkOutput("b_y1l", int'(capQ[9]), 'h12C);
      checkOutput("b_pix_hi", int'(capQ[11]), 'h107);
      checkOutput("b_last", int'(capQ[1194]), 'h1E0);
    end

    $display("[TB] rejects");
    applyStimulus(10, 0, 5, 0, 'h1234, rej);
    checkOutput("rej_x_model", int'(rej), 1);
    applyStimulus(0, 0, 0, 320, 'h1234, rej);
    checkOutput("rej_y_model", int'(rej), 1);

    $display("[TB] wide band with random ready");
    readyMode = 1;
    applyStimulus(0, 0, 239, 19, 'h001F, rej);
    waitDone(240 * 20, 60000);

    $display("[TB] random rectangles");
    for (int t = 0; t < 10; t++) begin
      x0 = $urandom_range(0, 239);
      y0 = $urandom_range(0, 319);
      x1 = x0 + $urandom_range(0, 15);
      y1 = y0 + $urandom_range(0, 15);
      if ($urandom_range(0, 5) == 0) begin
        n = x0; x0 = x1 + 1; x1 = n;
      end
      applyStimulus(x0, y0, x1, y1, $urandom_range(0, 65535), rej);
      if (!rej) waitDone((x1 - x0 + 1) * (y1 - y0 + 1), 4000);
    end

    $display("[TB] start while busy");
    readyMode = 0;
    applyStimulus(0, 0, 9, 9, 'hABCD, rej);
    waitXfers(11 + 20, 200);
    pulseStart(100, 100, 120, 120, 'h5555);
    waitDone(100, 500);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("ignored_busy", int'(o_busy), 0);

    $display("[TB] reset mid-fill");
    readyMode = 1;
    applyStimulus(0, 0, 9, 9, 'hABCD, rej);
    waitXfers(11 + 40, 500);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_rst_valid", int'(o_byte_valid), 0);
    checkOutput("mid_rst_busy", int'(o_busy), 0);
    checkOutput("mid_rst_dc", int'(o_dc), 0);
    checkOutput("mid_rst_done", int'(o_done), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    readyMode = 0;
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 0, 'hF800, rej);
    waitDone(1, 100);
    checkLiteralA("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
